// File: rtl/md_cell_pkg.sv
// Shared FSM state type, memory latency and FIFO sizing for the cell position reader.
package md_cell_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  // Slots already committed: reads still in the memory pipe plus words parked in the FIFO.
  function automatic logic [OCC_W:0] credit_use(input logic [OCC_W-1:0] inflight,
                                                input logic [OCC_W-1:0] occ);
    return {1'b0, inflight} + {1'b0, occ};
  endfunction

endpackage

// File: rtl/cell_rd_fifo.sv
// Synchronous show-ahead FIFO with occupancy; head word visible while not empty, zero when empty.
// Push into a full FIFO is refused, so the writer must hold credits against DEPTH.
module cell_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [OW-1:0]    occupancy
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (occupancy == '0);
  assign wr_en    = push && (occupancy != OW'(DEPTH));
  assign rd_en    = pop && !empty;
  assign pop_data = empty ? '0 : store[rptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      store[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) wptr_q <= bump(wptr_q);
      if (rd_en) rptr_q <= bump(rptr_q);
      occupancy <= occupancy + OW'(wr_en) - OW'(rd_en);
    end
  end

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count at cell address 0, then streams addresses 1..count as {index, last, position} words; first word 3 cycles after first read.
// Reads are credit-limited against the 4-entry FIFO so out_ready stalls never drop data; CELL_POS_RD_CLAMP_EN clamps oversize counts and sets count_err.
module cell_pos_reader
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [1:0]            WAIT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [OCC_W:0]        DEPTH_LIM = (OCC_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic                  last;
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [ADDR_WIDTH-1:0] ret_idx_q;
  logic [ADDR_WIDTH-1:0] raw_cnt;
  logic [ADDR_WIDTH-1:0] new_count;
  logic [1:0]            wait_q;
  logic [1:0]            wait_d;
  logic [RD_LATENCY-1:0] rd_pipe_q;
  logic [OCC_W-1:0]      inflight;
  logic [OCC_W-1:0]      occ;
  logic                  over;
  logic                  credit_ok;
  logic                  issue;
  logic                  cnt_load;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  drain_ok;
  entry_t                push_entry;
  entry_t                head;

  assign raw_cnt = mem_q[ADDR_WIDTH-1:0];
  assign over    = (raw_cnt > MAX_ADDR);

`ifdef CELL_POS_RD_CLAMP_EN
  assign new_count = over ? MAX_ADDR : raw_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_err <= 1'b0;
    end else if (cnt_load && over) begin
      count_err <= 1'b1;
    end
  end
`else
  assign new_count = raw_cnt;
  assign count_err = 1'b0;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(rd_pipe_q[i]);
    end
  end

  assign credit_ok = (credit_use(inflight, occ) < DEPTH_LIM);
  assign issue     = (state_q == STREAM) && credit_ok;
  assign push      = rd_pipe_q[RD_LATENCY-1];
  assign pop       = out_valid && out_ready;
  // The last word may leave in the same cycle the scan is judged drained.
  assign drain_ok  = (inflight == '0) &&
                     ((occ == '0) || ((occ == OCC_W'(1)) && pop));

  assign mem_rden    = (state_q == RD_CNT) || issue;
  assign mem_address = issue ? addr_q : '0;
  assign mem_wren    = 1'b0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RD_CNT;
      end
      RD_CNT: begin
        wait_d  = '0;
        state_d = WAIT_CNT;
      end
      WAIT_CNT: begin
        if (wait_q == WAIT_LAST) begin
          cnt_load = 1'b1;
          addr_d   = ADDR_WIDTH'(1);
          state_d  = (raw_cnt == '0) ? FINISH : STREAM;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      STREAM: begin
        if (issue) begin
          if (addr_q == last_addr_q) state_d = DRAIN;
          else                       addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_ok) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wait_q    <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      rd_pipe_q <= {rd_pipe_q[RD_LATENCY-2:0], issue};
    end
  end

  // Returned words arrive in issue order, so a running index tags them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      particle_count <= '0;
      last_addr_q    <= '0;
      ret_idx_q      <= '0;
    end else if (cnt_load) begin
      particle_count <= new_count;
      last_addr_q    <= over ? MAX_ADDR : raw_cnt;
      ret_idx_q      <= ADDR_WIDTH'(1);
    end else if (push) begin
      ret_idx_q <= ret_idx_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    push_entry.data  = mem_q;
    push_entry.index = ret_idx_q;
    push_entry.last  = (ret_idx_q == particle_count);
  end

  cell_rd_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .occupancy (occ)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_index = head.index;
  assign out_last  = head.last;

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed scoreboard bench for cell_pos_reader with a 2-cycle-latency cell memory model.
module tb_cell_pos_reader;

  localparam int DW   = 96;
  localparam int AW   = 8;
  localparam int PN   = 220;
  localparam int MAXA = PN - 1;
  localparam int BUDGET = 600;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_q;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic [AW-1:0] particle_count;
  logic          count_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] cell_mem [PN];
  logic [DW-1:0] s1;
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  cell_pos_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last),
    .particle_count (particle_count),
    .count_err      (count_err)
  );

  always @(posedge clk) begin
    s1    <= (mem_rden && int'(mem_address) < PN) ? cell_mem[mem_address] : {DW{1'b1}};
    mem_q <= s1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i, input int seed);
    logic [31:0] a, b, c;
    a = 32'(seed) * 32'h9E3779B1 + 32'(i);
    b = 32'(i) * 32'h01010101;
    c = 32'(seed) ^ ~32'(i);
    return {a, b, c};
  endfunction

  function automatic logic ready_at(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return ((c % 4) == 0) || ((c % 4) == 3);
  endfunction

  task automatic load_scan(input int cnt, input int seed);
    exp_t e;
    int   eff;
    int   lastref;
    cell_mem[0] = {32'hC0FFEE00 ^ 32'(seed), 56'h12345678ABCDEF, 8'(cnt)};
    for (int i = 1; i < PN; i++) cell_mem[i] = pat(i, seed);
    eff = (cnt > MAXA) ? MAXA : cnt;
`ifdef CELL_POS_RD_CLAMP_EN
    lastref = eff;
`else
    lastref = cnt;
`endif
    for (int i = 1; i <= eff; i++) begin
      e.data = pat(i, seed);
      e.idx  = AW'(i);
      e.last = (i == lastref);
      exp_q.push_back(e);
    end
  endtask

  task automatic reset_zero_check();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_particle_count", particle_count, 0);
    chk("rst_count_err", count_err, 0);
  endtask

  // Entered just after a rising edge; returns at the falling edge where done (or stop_cyc) is seen.
  task automatic run_scan(input int cnt, input int seed, input int mode, input int extra_start,
                          input int stop_cyc, output int first_rd, output int first_acc,
                          output int last_acc, output int done_cyc, output int nacc,
                          output int max_addr);
    exp_t e;
    first_rd = -1; first_acc = -1; last_acc = -1; done_cyc = -1; nacc = 0; max_addr = 0;
    load_scan(cnt, seed);
    start     = 1'b1;
    out_ready = ready_at(mode, 0);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (mem_rden && mem_address != '0) begin
        if (first_rd < 0) first_rd = cyc;
        if (int'(mem_address) > max_addr) max_addr = int'(mem_address);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_expected", out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("out_data", out_data, e.data);
          chk("out_index", out_index, e.idx);
          chk("out_last", out_last, e.last);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            nacc++;
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == stop_cyc) break;
      @(posedge clk); #1;
      start     = (cyc + 1 == extra_start);
      out_ready = ready_at(mode, cyc + 1);
    end
    start = 1'b0;
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_low_idle", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int fr, fa, la, dc, na, ma;
    logic any_rd;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_zero_check();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // count=5 with out_ready high: back-to-back words, done right after last.
    run_scan(5, 11, 0, -1, -1, fr, fa, la, dc, na, ma);
    chk("c5_words", na, 5);
    chk("c5_first_rd_cycle", fr, 4);
    chk("c5_first_latency", fa - fr, 3);
    chk("c5_back_to_back", la - fa, 4);
    chk("c5_done_cycle", dc, 12);
    chk("c5_done_after_last", dc - la, 1);
    chk("c5_count", particle_count, 5);
    chk("c5_count_err", count_err, 0);
    chk("c5_max_addr", ma, 5);
    after_done();

    // count=0: straight to done without any output.
    run_scan(0, 22, 0, -1, -1, fr, fa, la, dc, na, ma);
    chk("c0_words", na, 0);
    chk("c0_no_stream_read", fr, -1);
    chk("c0_done_cycle", dc, 4);
    chk("c0_count", particle_count, 0);
    after_done();

    // count=8 with out_ready pattern 1,0,0,1: stable while stalled, none lost.
    run_scan(8, 33, 1, -1, -1, fr, fa, la, dc, na, ma);
    chk("c8_words", na, 8);
    chk("c8_done_seen", dc > 0, 1);
    chk("c8_done_after_last", dc - la, 1);
    chk("c8_count", particle_count, 8);
    after_done();

    // Second start during a scan is ignored.
    run_scan(6, 44, 0, 6, -1, fr, fa, la, dc, na, ma);
    chk("c6_words", na, 6);
    chk("c6_done_cycle", dc, 13);
    after_done();
    any_rd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      any_rd = any_rd | mem_rden | busy;
    end
    chk("c6_no_restart", any_rd, 0);
    @(posedge clk); #1;

    // Reset in the middle of a count=10 stream, then a clean rescan.
    run_scan(10, 55, 0, -1, 9, fr, fa, la, dc, na, ma);
    chk("r10_in_stream", busy, 1);
    rst_n = 1'b0;
    #1;
    reset_zero_check();
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    any_rd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      any_rd = any_rd | mem_rden | busy | out_valid;
    end
    chk("r10_idle_after_reset", any_rd, 0);
    @(posedge clk); #1;
    run_scan(10, 66, 0, -1, -1, fr, fa, la, dc, na, ma);
    chk("r10_words", na, 10);
    chk("r10_first_acc", fa, 7);
    chk("r10_done_cycle", dc, 17);
    chk("r10_count", particle_count, 10);
    after_done();

    // count=250 exceeds the memory: reads stop at the last address.
    run_scan(250, 77, 0, -1, -1, fr, fa, la, dc, na, ma);
    chk("c250_words", na, MAXA);
    chk("c250_max_addr", ma, MAXA);
    chk("c250_done_after_last", dc - la, 1);
`ifdef CELL_POS_RD_CLAMP_EN
    chk("c250_count", particle_count, MAXA);
    chk("c250_count_err", count_err, 1);
`else
    chk("c250_count", particle_count, 250);
    chk("c250_count_err", count_err, 0);
`endif
    after_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cell_pos_reader.md
CELL_POS_READER -- requirements
Module: cell_pos_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning packed {posz, posy, posx} word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning cell-memory address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, meaning cell-memory depth in words, address 0 included.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a cell scan.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last particle is accepted downstream.
REQ-010 mem_address  out  ADDR_WIDTH  cell-memory read address.
REQ-011 mem_rden  out  1  cell-memory read enable.
REQ-012 mem_wren  out  1  cell-memory write enable, driven constant 0.
REQ-013 mem_q  in  DATA_WIDTH  cell-memory read data, valid 2 cycles after the rden cycle.
REQ-014 out_valid, out_ready  out/in  1  downstream valid/ready handshake.
REQ-015 out_data  out  DATA_WIDTH  particle position word.
REQ-016 out_index  out  ADDR_WIDTH  particle address (1..count) of out_data.
REQ-017 out_last  out  1  marks the final particle of the scan.
REQ-018 particle_count  out  ADDR_WIDTH  count latched from address 0.
REQ-019 count_err  out  1  sticky flag; set only when CELL_POS_RD_CLAMP_EN is defined.

Function
REQ-020 FSM states SHALL be IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH.
- IDLE->RD_CNT on start.
- RD_CNT: issues rden at address 0 for one cycle.
- WAIT_CNT: 2 cycles; count = mem_q[ADDR_WIDTH-1:0].
- STREAM: issues reads for addresses 1..count.
- DRAIN: waits for the in-flight reads and the FIFO to empty.
- FINISH: pulses done, then returns to IDLE.
REQ-021 count==0 SHALL go WAIT_CNT->FINISH with no out_valid.
REQ-022 Read issue SHALL be credit-based: rden only when in-flight reads + FIFO occupancy < FIFO_DEPTH (4); no returned word is ever dropped.
REQ-023 Returned words SHALL enter a 4-entry FIFO; out_valid = FIFO not empty; a word is transferred on out_valid && out_ready.
REQ-024 out_data, out_index and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 With out_ready held high, particle 1 SHALL appear 3 cycles after the first STREAM rden and sustain 1 word/cycle.
REQ-026 start while busy SHALL be ignored.
REQ-027 out_last SHALL be 1 only with out_index==count.
REQ-028 The address counter SHALL never exceed PARTICLE_NUM-1 (no wrap to 0).

Reset
REQ-029 rst_n low SHALL immediately force IDLE, empty the FIFO, clear credits, and set every output to 0 (count_err cleared).
REQ-030 Reset mid-scan SHALL discard in-flight data; the first scan after reset begins only on a new start.

Configuration
REQ-031 With CELL_POS_RD_CLAMP_EN defined, a count > PARTICLE_NUM-1 SHALL be clamped to PARTICLE_NUM-1 and SHALL set count_err.
REQ-032 Without CELL_POS_RD_CLAMP_EN, the count SHALL be used unclamped, reads SHALL be truncated at PARTICLE_NUM-1 per REQ-028, and count_err SHALL be tied 0.

Structure
REQ-033 Package md_cell_pkg SHALL hold the FSM state enum, RD_LATENCY=2 and FIFO_DEPTH=4.
REQ-034 The FIFO SHALL be the sub-module cell_rd_fifo (synchronous, show-ahead, with occupancy output).

Verification
REQ-035 count=5, out_ready=1: start -> indices 1..5 on consecutive cycles, out_last on 5, done one cycle later.
REQ-036 count=0: start -> no out_valid, done pulse, busy low in IDLE.
REQ-037 count=8, out_ready toggling 1,0,0,1: all 8 words are delivered in order, none lost or duplicated, data stable while stalled.
REQ-038 count=250, macro defined: 219 words are delivered and count_err=1; macro undefined: reads stop at address 219 and count_err=0.
REQ-039 rst_n low during STREAM of count=10: outputs are 0 immediately; a new start then delivers a clean scan from index 1.
REQ-040 start pulsed again during a scan: ignored, and the scan completes unchanged.
